// File: rtl/rr_arbiter_ctrl_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and default sizing.
package rr_arbiter_ctrl_pkg;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RSVD    = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter_ctrl_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_ctrl_if
  import rr_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned N = DEF_N
);
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           expire;

  modport master (output req, input grant, input grant_id, input busy, input expire);
  modport slave  (input req, output grant, output grant_id, output busy, output expire);

endinterface

// File: rtl/rr_arbiter_ctrl_pick.sv
// Rotating-priority search: first set req bit starting at ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);
  localparam int unsigned IDW = $clog2(N);

  // Walk the order backwards so the candidate closest to ptr is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      int unsigned    j;
      logic [IDW-1:0] jj;
      j = 32'(ptr) + 32'(k);
      if (j >= N) j = j - N;
      jj = IDW'(j);
      if (req[jj]) begin
        valid = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter for a single-owner resource with a bounded hold time and a dead cycle between owners.
module rr_arbiter_ctrl
  import rr_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  rr_arbiter_ctrl_if.slave bus
);
  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned CW  = $clog2(MAX_HOLD + 1);

  state_t         state, state_nxt;
  logic [N-1:0]   grant_q, grant_nxt;
  logic [IDW-1:0] grant_id_q, grant_id_nxt;
  logic           busy_q, busy_nxt;
  logic           expire_q, expire_nxt;
  logic [IDW-1:0] ptr_q, ptr_nxt;
  logic [CW-1:0]  cnt_q, cnt_nxt;

  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic           owner_req;

  rr_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Only the owner's request matters while granted.
  assign owner_req = |(bus.req & grant_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      expire_q   <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      grant_id_q <= grant_id_nxt;
      busy_q     <= busy_nxt;
      expire_q   <= expire_nxt;
      ptr_q      <= ptr_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    grant_id_nxt = grant_id_q;
    busy_nxt     = busy_q;
    expire_nxt   = 1'b0;
    ptr_nxt      = ptr_q;
    cnt_nxt      = cnt_q;

    unique case (state)
      ST_IDLE, ST_RELEASE: begin
        if (pick_valid) begin
          state_nxt    = ST_GRANT;
          grant_nxt    = N'(1) << pick_idx;
          grant_id_nxt = pick_idx;
          busy_nxt     = 1'b1;
          cnt_nxt      = CW'(1);
        end else begin
          state_nxt    = ST_IDLE;
          grant_nxt    = '0;
          grant_id_nxt = '0;
          busy_nxt     = 1'b0;
          cnt_nxt      = '0;
        end
      end

      ST_GRANT: begin
        if (!owner_req || cnt_q == CW'(MAX_HOLD)) begin
          // A dropped request takes precedence, so hitting the limit on that cycle is not a preemption.
          state_nxt    = ST_RELEASE;
          expire_nxt   = owner_req;
          ptr_nxt      = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + IDW'(1);
          grant_nxt    = '0;
          grant_id_nxt = '0;
          busy_nxt     = 1'b0;
          cnt_nxt      = '0;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end

      default: begin
        state_nxt    = ST_IDLE;
        grant_nxt    = '0;
        grant_id_nxt = '0;
        busy_nxt     = 1'b0;
        cnt_nxt      = '0;
      end
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.expire   = expire_q;

endmodule
